timer_averager_mc: RTL and testbench
====================================

Name: timer_averager_mc

Overview:
- Multi-channel successor to the single-channel timer averager functional core.
- Measures START->STOP intervals on NUM_CHANNELS independent channels with a parametrised counter width.
- Per channel: accumulates power-of-two sample series into averages, saturation flags and sticky overrun flags.
- All completed measurements are merged onto one valid/ready result stream by round-robin arbitration. Sits behind an AXI-Lite register wrapper (separate block).

Parameters:
- NUM_CHANNELS, 4, number of independent timer channels (1..16).
- CNT_WIDTH, 32, interval counter and result width in bits (8..48).
- MAX_AVG_LOG2, 16, largest permitted log2 of samples per averaging series.
- DEFAULT_AVG_LOG2, 1, series length (log2) used after reset until AVG_LIMIT is first written.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  NUM_CHANNELS  per-channel single-cycle start pulse.
- STOP  in  NUM_CHANNELS  per-channel single-cycle stop pulse.
- AVG_ENABLE  in  1  averaging enable, all channels.
- AVG_LIMIT  in  5  log2 samples per series; values above MAX_AVG_LOG2 are clamped.
- AVG_LIMIT_WE  in  1  load strobe for AVG_LIMIT.
- CLEAR  in  1  pulse: clears counts, accumulators, sticky flags and pending results; does not stop running timers.
- MSMT_VALUE  out  CNT_WIDTH  result interval in clock cycles.
- MSMT_CHANNEL  out  4  channel index of the result.
- MSMT_SAT  out  1  result saturated.
- MSMT_VALID  out  1  result stream valid.
- MSMT_READY  in  1  result stream ready.
- AVG_VALUE  out  NUM_CHANNELS*CNT_WIDTH  last completed average per channel, channel 0 in the LSBs.
- AVG_DONE  out  NUM_CHANNELS  one-cycle pulse when a channel's average updates.
- MSMT_COUNT  out  NUM_CHANNELS*32  captures per channel; wraps modulo 2^32.
- OVERRUN  out  NUM_CHANNELS  sticky: a pending result was overwritten.

Behaviour:
- Reset values:
  - all outputs 0; all channels IDLE;
  - accumulators and sample counters 0;
  - effective AVG_LIMIT = DEFAULT_AVG_LOG2.
- Channel FSM, IDLE:
  - START -> RUN, counter cleared.
  - STOP alone is ignored.
  - START and STOP together: START wins.
- Channel FSM, RUN:
  - Counter increments each cycle and saturates at all-ones; the saturation flag is latched for this interval.
  - STOP at cycle T0+k (T0 = START cycle, k>=1) captures elapsed = k, saturated to 2^CNT_WIDTH-1 with SAT=1, then -> IDLE.
  - START alone restarts: counter cleared, no capture.
  - START and STOP together: capture k, stay in RUN with the counter restarted (back-to-back interval).
- Capture:
  - Sets pending[c] and increments MSMT_COUNT[c] in cycle T+1 (T = STOP cycle).
  - If pending[c] is still set, the value is overwritten and OVERRUN[c] is set.
- Output stage:
  - One output register. When it is empty or being handshaken (MSMT_VALID & MSMT_READY), it loads the next pending channel in round-robin order, starting after the last granted channel.
  - Earliest MSMT_VALID is cycle T+2.
  - Outputs are stable while MSMT_VALID=1 and MSMT_READY=0.
  - Throughput is one result per cycle.
- Averaging (AVG_ENABLE=1):
  - Each capture adds elapsed to acc[c], which is CNT_WIDTH+MAX_AVG_LOG2 bits wide and never overflows.
  - On the 2^L-th sample: AVG_VALUE[c] <= (acc+elapsed)>>L (truncating), AVG_DONE[c] pulses in the same cycle as the pending update, and acc and sample count clear.
- Averaging control:
  - AVG_ENABLE=0 holds acc and sample counts at 0; AVG_VALUE retains its value.
  - AVG_LIMIT_WE aborts the in-progress series on every channel; no AVG_DONE is produced.
- CLEAR:
  - Zeroes MSMT_COUNT, acc, sample counts, OVERRUN and pending.
  - A capture in the same cycle as CLEAR is discarded.
  - An output already presented on MSMT_VALID completes normally.
- RESET mid-interval: the channel returns to IDLE; no result is produced.

Decomposition:
- Package timer_averager_pkg holds:
  - channel state enum (IDLE, RUN);
  - CH_IDX_W = 4;
  - MSMT_COUNT_W = 32;
  - AVG_LIMIT_W = 5;
  - clamp function for AVG_LIMIT.
- Sub-module timer_averager_channel: FSM, counter, saturation, accumulator, sample counter, MSMT_COUNT. Instantiated NUM_CHANNELS times via generate.
- Top level holds: pending registers, overrun flags, round-robin arbiter, output register.

Test Plan:
- Timing: START ch0 at cycle 10, STOP at cycle 110 -> MSMT_VALUE=100, MSMT_CHANNEL=0, SAT=0, MSMT_VALID at cycle 112; MSMT_COUNT[0]=1.
- Saturation: CNT_WIDTH=8, STOP 300 cycles after START -> MSMT_VALUE=255, MSMT_SAT=1.
- Averaging: AVG_ENABLE=1, AVG_LIMIT=2; intervals 10, 11, 12, 14 -> AVG_VALUE[0]=11, one AVG_DONE[0] pulse; fifth capture produces no pulse.
- Arbitration: all 4 channels STOP in the same cycle with MSMT_READY=1 -> results in channel order 0,1,2,3 on consecutive cycles. Repeat with MSMT_READY held low for 5 cycles -> values held stable, no loss.
- Overrun: MSMT_READY=0 and ch1 captures 40 then 50 -> OVERRUN[1]=1; delivered value is 50. CLEAR -> OVERRUN=0, MSMT_COUNT=0.
- Restart: START+STOP together on ch2 at cycle 30 after START at cycle 20 -> result 10; next STOP at cycle 37 -> result 7. RESET at cycle 5 of an interval -> no result.

Source files
------------

// File: rtl/timer_averager_pkg.sv
// Shared types, widths and helpers for the multi-channel timer averager.
package timer_averager_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } ch_state_e;

    localparam int unsigned CH_IDX_W     = 4;
    localparam int unsigned MSMT_COUNT_W = 32;
    localparam int unsigned AVG_LIMIT_W  = 5;

    // Limit a requested series length (log2) to the widest the accumulator supports.
    function automatic logic [AVG_LIMIT_W-1:0] clamp_avg_limit(
        input logic [AVG_LIMIT_W-1:0] limit,
        input int unsigned            max_log2
    );
        if (32'(limit) > max_log2) begin
            return AVG_LIMIT_W'(max_log2);
        end
        return limit;
    endfunction

endpackage

// File: rtl/timer_averager_channel.sv
// One timer channel: START/STOP interval FSM with saturating counter, capture strobe,
// power-of-two series averager and a free-running capture count.
module timer_averager_channel
    import timer_averager_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned MAX_AVG_LOG2 = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_clear,
    input  logic                    i_avg_enable,
    input  logic                    i_avg_limit_we,
    input  logic [AVG_LIMIT_W-1:0]  i_avg_log2,
    output logic                    o_cap_valid,
    output logic [CNT_WIDTH-1:0]    o_cap_value,
    output logic                    o_cap_sat,
    output logic [CNT_WIDTH-1:0]    o_avg_value,
    output logic                    o_avg_done,
    output logic [MSMT_COUNT_W-1:0] o_msmt_count
);

    localparam int unsigned ACC_W = CNT_WIDTH + MAX_AVG_LOG2;
    localparam int unsigned SMP_W = MAX_AVG_LOG2 + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [SMP_W-1:0]     SMP_ONE = SMP_W'(1);

    ch_state_e                r_state;
    logic [CNT_WIDTH-1:0]     r_cnt;
    logic                     r_sat;
    logic [ACC_W-1:0]         r_acc;
    logic [SMP_W-1:0]         r_samples;
    logic [CNT_WIDTH-1:0]     r_avg_value;
    logic                     r_avg_done;
    logic [MSMT_COUNT_W-1:0]  r_msmt_count;

    logic                     w_cap;
    logic [ACC_W-1:0]         w_sum;
    logic [SMP_W-1:0]         w_target;
    logic                     w_last;

    // r_cnt already holds the elapsed cycle count k in the STOP cycle, so it is the result.
    assign w_cap       = (r_state == StRun) && i_stop;
    assign o_cap_valid = w_cap;
    assign o_cap_value = r_cnt;
    assign o_cap_sat   = r_sat;

    assign w_sum    = r_acc + ACC_W'(r_cnt);
    assign w_target = SMP_ONE << i_avg_log2;
    assign w_last   = (r_samples + SMP_ONE) == w_target;

    // Interval FSM; START loads 1 so the count reads k in cycle T0+k, saturating at all-ones.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state <= StRun;
                        r_cnt   <= CNT_ONE;
                        r_sat   <= 1'b0;
                    end
                end
                StRun: begin
                    if (i_start) begin
                        r_cnt <= CNT_ONE;
                        r_sat <= 1'b0;
                    end else if (i_stop) begin
                        r_state <= StIdle;
                    end else if (r_cnt == CNT_MAX) begin
                        r_sat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Capture counter; a capture coinciding with CLEAR is dropped.
    always_ff @(posedge CLK) begin
        if (RESET || i_clear) begin
            r_msmt_count <= '0;
        end else if (w_cap) begin
            r_msmt_count <= r_msmt_count + MSMT_COUNT_W'(1);
        end
    end

    // Series accumulator; the last sample of a series publishes the truncated mean.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc       <= '0;
            r_samples   <= '0;
            r_avg_value <= '0;
            r_avg_done  <= 1'b0;
        end else begin
            r_avg_done <= 1'b0;
            if (i_clear || i_avg_limit_we || !i_avg_enable) begin
                r_acc     <= '0;
                r_samples <= '0;
            end else if (w_cap) begin
                if (w_last) begin
                    r_avg_value <= CNT_WIDTH'(w_sum >> i_avg_log2);
                    r_avg_done  <= 1'b1;
                    r_acc       <= '0;
                    r_samples   <= '0;
                end else begin
                    r_acc     <= w_sum;
                    r_samples <= r_samples + SMP_ONE;
                end
            end
        end
    end

    assign o_avg_value  = r_avg_value;
    assign o_avg_done   = r_avg_done;
    assign o_msmt_count = r_msmt_count;

endmodule

// File: rtl/timer_averager_mc.sv
// Multi-channel timer averager: per-channel pending slots with overrun detection, merged
// onto one valid/ready result stream through a round-robin arbiter and output register.
module timer_averager_mc
    import timer_averager_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS     = 4,
    parameter int unsigned CNT_WIDTH        = 32,
    parameter int unsigned MAX_AVG_LOG2     = 16,
    parameter int unsigned DEFAULT_AVG_LOG2 = 1
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [NUM_CHANNELS-1:0]            START,
    input  logic [NUM_CHANNELS-1:0]            STOP,
    input  logic                               AVG_ENABLE,
    input  logic [AVG_LIMIT_W-1:0]             AVG_LIMIT,
    input  logic                               AVG_LIMIT_WE,
    input  logic                               CLEAR,
    output logic [CNT_WIDTH-1:0]               MSMT_VALUE,
    output logic [CH_IDX_W-1:0]                MSMT_CHANNEL,
    output logic                               MSMT_SAT,
    output logic                               MSMT_VALID,
    input  logic                               MSMT_READY,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0]  AVG_VALUE,
    output logic [NUM_CHANNELS-1:0]            AVG_DONE,
    output logic [NUM_CHANNELS*MSMT_COUNT_W-1:0] MSMT_COUNT,
    output logic [NUM_CHANNELS-1:0]            OVERRUN
);

    logic [AVG_LIMIT_W-1:0] r_avg_log2;

    logic [NUM_CHANNELS-1:0] w_cap_valid;
    logic [CNT_WIDTH-1:0]    w_cap_value [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_cap_sat;

    logic [NUM_CHANNELS-1:0] r_pend;
    logic [CNT_WIDTH-1:0]    r_pend_val [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_pend_sat;
    logic [NUM_CHANNELS-1:0] r_overrun;

    logic                    r_out_valid;
    logic [CNT_WIDTH-1:0]    r_out_value;
    logic [CH_IDX_W-1:0]     r_out_ch;
    logic                    r_out_sat;
    logic [CH_IDX_W-1:0]     r_last;

    logic                    w_lo_any, w_hi_any;
    logic [CH_IDX_W-1:0]     w_lo_idx, w_hi_idx;
    logic [CNT_WIDTH-1:0]    w_lo_val, w_hi_val;
    logic                    w_lo_sat, w_hi_sat;
    logic [CH_IDX_W-1:0]     w_gnt_idx;
    logic [CNT_WIDTH-1:0]    w_gnt_val;
    logic                    w_gnt_sat;
    logic                    w_out_free;
    logic                    w_take;
    logic [NUM_CHANNELS-1:0] w_gnt_oh;

    // Effective series length; a write is clamped to what the accumulator can hold.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_avg_log2 <= AVG_LIMIT_W'(DEFAULT_AVG_LOG2);
        end else if (AVG_LIMIT_WE) begin
            r_avg_log2 <= clamp_avg_limit(AVG_LIMIT, MAX_AVG_LOG2);
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        timer_averager_channel #(
            .CNT_WIDTH    (CNT_WIDTH),
            .MAX_AVG_LOG2 (MAX_AVG_LOG2)
        ) u_ch (
            .CLK            (CLK),
            .RESET          (RESET),
            .i_start        (START[g]),
            .i_stop         (STOP[g]),
            .i_clear        (CLEAR),
            .i_avg_enable   (AVG_ENABLE),
            .i_avg_limit_we (AVG_LIMIT_WE),
            .i_avg_log2     (r_avg_log2),
            .o_cap_valid    (w_cap_valid[g]),
            .o_cap_value    (w_cap_value[g]),
            .o_cap_sat      (w_cap_sat[g]),
            .o_avg_value    (AVG_VALUE[g*CNT_WIDTH +: CNT_WIDTH]),
            .o_avg_done     (AVG_DONE[g]),
            .o_msmt_count   (MSMT_COUNT[g*MSMT_COUNT_W +: MSMT_COUNT_W])
        );
    end

    // Round-robin search: lowest pending channel above the last grant, else lowest overall.
    always_comb begin
        w_lo_any = 1'b0;
        w_lo_idx = '0;
        w_lo_val = '0;
        w_lo_sat = 1'b0;
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        w_hi_val = '0;
        w_hi_sat = 1'b0;
        for (int j = int'(NUM_CHANNELS) - 1; j >= 0; j--) begin
            if (r_pend[j]) begin
                w_lo_any = 1'b1;
                w_lo_idx = CH_IDX_W'(j);
                w_lo_val = r_pend_val[j];
                w_lo_sat = r_pend_sat[j];
                if (CH_IDX_W'(j) > r_last) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = CH_IDX_W'(j);
                    w_hi_val = r_pend_val[j];
                    w_hi_sat = r_pend_sat[j];
                end
            end
        end
    end

    assign w_gnt_idx  = w_hi_any ? w_hi_idx : w_lo_idx;
    assign w_gnt_val  = w_hi_any ? w_hi_val : w_lo_val;
    assign w_gnt_sat  = w_hi_any ? w_hi_sat : w_lo_sat;
    assign w_out_free = !r_out_valid || MSMT_READY;
    // Pending slots are being wiped by CLEAR, so nothing is granted in that cycle.
    assign w_take     = w_out_free && w_lo_any && !CLEAR;

    // One-hot form of the grant, used to release the granted pending slot.
    always_comb begin
        w_gnt_oh = '0;
        for (int j = 0; j < int'(NUM_CHANNELS); j++) begin
            w_gnt_oh[j] = w_take && (w_gnt_idx == CH_IDX_W'(j));
        end
    end

    // Pending slots; a capture onto a slot not drained this cycle overwrites it and flags overrun.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pend     <= '0;
            r_pend_sat <= '0;
            r_overrun  <= '0;
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                r_pend_val[c] <= '0;
            end
        end else begin
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                if (CLEAR) begin
                    r_pend[c]    <= 1'b0;
                    r_overrun[c] <= 1'b0;
                end else if (w_cap_valid[c]) begin
                    r_pend[c]     <= 1'b1;
                    r_pend_val[c] <= w_cap_value[c];
                    r_pend_sat[c] <= w_cap_sat[c];
                    if (r_pend[c] && !w_gnt_oh[c]) begin
                        r_overrun[c] <= 1'b1;
                    end
                end else if (w_gnt_oh[c]) begin
                    r_pend[c] <= 1'b0;
                end
            end
        end
    end

    // Output register: refilled whenever empty or handshaken, held under backpressure.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_valid <= 1'b0;
            r_out_value <= '0;
            r_out_ch    <= '0;
            r_out_sat   <= 1'b0;
            r_last      <= CH_IDX_W'(NUM_CHANNELS - 1);
        end else if (w_out_free) begin
            if (w_take) begin
                r_out_valid <= 1'b1;
                r_out_value <= w_gnt_val;
                r_out_ch    <= w_gnt_idx;
                r_out_sat   <= w_gnt_sat;
                r_last      <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign MSMT_VALID   = r_out_valid;
    assign MSMT_VALUE   = r_out_value;
    assign MSMT_CHANNEL = r_out_ch;
    assign MSMT_SAT     = r_out_sat;
    assign OVERRUN      = r_overrun;

endmodule

// File: tb/tb_timer_averager_mc.sv
// Directed bench for timer_averager_mc: a 32-bit instance for most scenarios and an
// 8-bit instance for counter saturation.
module tb_timer_averager_mc;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int W8 = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   start, stop, start8, stop8;
    logic           avg_en, avg_we, clear, ready, ready8;
    logic [4:0]     avg_lim;

    logic [W-1:0]   msmt_value;
    logic [3:0]     msmt_channel;
    logic           msmt_sat, msmt_valid;
    logic [N*W-1:0] avg_value;
    logic [N-1:0]   avg_done, overrun;
    logic [N*32-1:0] msmt_count;

    logic [W8-1:0]   msmt_value8;
    logic [3:0]      msmt_channel8;
    logic            msmt_sat8, msmt_valid8;
    logic [N*W8-1:0] avg_value8;
    logic [N-1:0]    avg_done8, overrun8;
    logic [N*32-1:0] msmt_count8;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt0 = 0;

    timer_averager_mc #(.NUM_CHANNELS(N), .CNT_WIDTH(W)) dut (
        .CLK(clk), .RESET(rst), .START(start), .STOP(stop), .AVG_ENABLE(avg_en),
        .AVG_LIMIT(avg_lim), .AVG_LIMIT_WE(avg_we), .CLEAR(clear),
        .MSMT_VALUE(msmt_value), .MSMT_CHANNEL(msmt_channel), .MSMT_SAT(msmt_sat),
        .MSMT_VALID(msmt_valid), .MSMT_READY(ready), .AVG_VALUE(avg_value),
        .AVG_DONE(avg_done), .MSMT_COUNT(msmt_count), .OVERRUN(overrun)
    );

    timer_averager_mc #(.NUM_CHANNELS(N), .CNT_WIDTH(W8)) dut8 (
        .CLK(clk), .RESET(rst), .START(start8), .STOP(stop8), .AVG_ENABLE(avg_en),
        .AVG_LIMIT(avg_lim), .AVG_LIMIT_WE(avg_we), .CLEAR(clear),
        .MSMT_VALUE(msmt_value8), .MSMT_CHANNEL(msmt_channel8), .MSMT_SAT(msmt_sat8),
        .MSMT_VALID(msmt_valid8), .MSMT_READY(ready8), .AVG_VALUE(avg_value8),
        .AVG_DONE(avg_done8), .MSMT_COUNT(msmt_count8), .OVERRUN(overrun8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (avg_done[0]) done_cnt0++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // START at T0, STOP at T0+len; returns in cycle T+1 (T = STOP cycle).
    task automatic run_interval(input int ch, input int len);
        start = '0; start[ch] = 1'b1;
        tick();
        start = '0;
        repeat (len - 1) tick();
        stop = '0; stop[ch] = 1'b1;
        tick();
        stop = '0;
    endtask

    task automatic test_reset();
        n_tests++; if (msmt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", msmt_valid); end
        n_tests++; if (msmt_value !== '0 || msmt_channel !== 4'd0 || msmt_sat !== 1'b0) begin
            n_fail++; $display("FAIL reset_result: got value %0d ch %0d sat %0b want 0 0 0", msmt_value, msmt_channel, msmt_sat); end
        n_tests++; if (avg_value !== '0 || avg_done !== '0) begin
            n_fail++; $display("FAIL reset_avg: got value %0h done %0b want 0", avg_value, avg_done); end
        n_tests++; if (msmt_count !== '0 || overrun !== '0) begin
            n_fail++; $display("FAIL reset_counts: got count %0h overrun %0b want 0", msmt_count, overrun); end
        // STOP with the channel idle must be ignored
        stop = 4'b0001; tick(); stop = '0; tick(); tick();
        n_tests++; if (msmt_valid !== 1'b0 || msmt_count[31:0] !== 32'd0) begin
            n_fail++; $display("FAIL idle_stop: got valid %0b count %0d want 0 0", msmt_valid, msmt_count[31:0]); end
    endtask

    task automatic test_timing();
        ready = 1'b1;
        run_interval(0, 100);
        n_tests++; if (msmt_valid !== 1'b0) begin n_fail++; $display("FAIL timing_early: got valid %0b at T+1 want 0", msmt_valid); end
        n_tests++; if (msmt_count[31:0] !== 32'd1) begin n_fail++; $display("FAIL timing_count: got %0d want 1", msmt_count[31:0]); end
        tick();
        n_tests++; if (msmt_valid !== 1'b1 || msmt_value !== 32'd100 || msmt_channel !== 4'd0 || msmt_sat !== 1'b0) begin
            n_fail++; $display("FAIL timing_result: got valid %0b value %0d ch %0d sat %0b want 1 100 0 0",
                               msmt_valid, msmt_value, msmt_channel, msmt_sat); end
        tick();
        n_tests++; if (msmt_valid !== 1'b0) begin n_fail++; $display("FAIL timing_drain: got valid %0b want 0", msmt_valid); end
    endtask

    task automatic test_saturation();
        ready8 = 1'b1;
        start8 = 4'b0001; tick(); start8 = '0;
        repeat (299) tick();
        stop8 = 4'b0001; tick(); stop8 = '0;
        tick();
        n_tests++; if (msmt_valid8 !== 1'b1 || msmt_value8 !== 8'd255 || msmt_sat8 !== 1'b1) begin
            n_fail++; $display("FAIL sat_result: got valid %0b value %0d sat %0b want 1 255 1", msmt_valid8, msmt_value8, msmt_sat8); end
        tick();
    endtask

    task automatic test_averaging();
        int d0;
        avg_en = 1'b1; avg_lim = 5'd2; avg_we = 1'b1; tick(); avg_we = 1'b0;
        d0 = done_cnt0;
        run_interval(0, 10);
        run_interval(0, 11);
        run_interval(0, 12);
        tick();
        n_tests++; if (done_cnt0 != d0) begin n_fail++; $display("FAIL avg_early_done: got %0d pulses want 0", done_cnt0 - d0); end
        run_interval(0, 14);
        n_tests++; if (avg_done[0] !== 1'b1 || avg_value[31:0] !== 32'd11) begin
            n_fail++; $display("FAIL avg_result: got done %0b value %0d want 1 11", avg_done[0], avg_value[31:0]); end
        tick();
        n_tests++; if (done_cnt0 - d0 != 1) begin n_fail++; $display("FAIL avg_one_pulse: got %0d pulses want 1", done_cnt0 - d0); end
        run_interval(0, 9);
        tick();
        n_tests++; if (done_cnt0 - d0 != 1 || avg_value[31:0] !== 32'd11) begin
            n_fail++; $display("FAIL avg_fifth: got %0d pulses value %0d want 1 11", done_cnt0 - d0, avg_value[31:0]); end
    endtask

    task automatic test_avg_abort();
        // One sample (9) is in flight; rewriting the limit must discard it
        avg_lim = 5'd1; avg_we = 1'b1; tick(); avg_we = 1'b0;
        run_interval(0, 20);
        n_tests++; if (avg_done[0] !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got done %0b want 0", avg_done[0]); end
        run_interval(0, 30);
        n_tests++; if (avg_done[0] !== 1'b1 || avg_value[31:0] !== 32'd25) begin
            n_fail++; $display("FAIL abort_result: got done %0b value %0d want 1 25", avg_done[0], avg_value[31:0]); end
        avg_en = 1'b0; tick();
        run_interval(0, 40);
        run_interval(0, 50);
        n_tests++; if (avg_done[0] !== 1'b0 || avg_value[31:0] !== 32'd25) begin
            n_fail++; $display("FAIL avg_disabled: got done %0b value %0d want 0 25", avg_done[0], avg_value[31:0]); end
        tick();
    endtask

    // Channel c starts 3-c cycles after channel 3; all stop together -> values 17..20.
    task automatic stagger_all();
        start = 4'b1000; tick();
        start = 4'b0100; tick();
        start = 4'b0010; tick();
        start = 4'b0001; tick();
        start = '0;
        repeat (16) tick();
        stop = 4'b1111; tick(); stop = '0;
    endtask

    task automatic test_arbitration();
        rst = 1'b1; tick(); rst = 1'b0;
        ready = 1'b1;
        stagger_all();
        tick();
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (msmt_valid !== 1'b1 || msmt_channel !== 4'(k) || msmt_value !== 32'(17 + k)) begin
                n_fail++; $display("FAIL arb_order%0d: got valid %0b ch %0d value %0d want 1 %0d %0d",
                                   k, msmt_valid, msmt_channel, msmt_value, k, 17 + k); end
            tick();
        end
        n_tests++; if (msmt_valid !== 1'b0) begin n_fail++; $display("FAIL arb_drain: got valid %0b want 0", msmt_valid); end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        stagger_all();
        tick();
        for (int h = 0; h < 5; h++) begin
            n_tests++; if (msmt_valid !== 1'b1 || msmt_channel !== 4'd0 || msmt_value !== 32'd17) begin
                n_fail++; $display("FAIL bp_hold%0d: got valid %0b ch %0d value %0d want 1 0 17",
                                   h, msmt_valid, msmt_channel, msmt_value); end
            if (h < 4) tick();
        end
        ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            n_tests++; if (msmt_valid !== 1'b1 || msmt_channel !== 4'(k) || msmt_value !== 32'(17 + k)) begin
                n_fail++; $display("FAIL bp_order%0d: got valid %0b ch %0d value %0d want 1 %0d %0d",
                                   k, msmt_valid, msmt_channel, msmt_value, k, 17 + k); end
        end
        tick();
        n_tests++; if (msmt_valid !== 1'b0 || overrun !== '0) begin
            n_fail++; $display("FAIL bp_drain: got valid %0b overrun %0b want 0 0", msmt_valid, overrun); end
    endtask

    task automatic test_overrun_clear();
        ready = 1'b0;
        run_interval(0, 5);
        run_interval(1, 40);
        run_interval(1, 50);
        n_tests++; if (overrun !== 4'b0010) begin n_fail++; $display("FAIL overrun_flag: got %0b want 0010", overrun); end
        n_tests++; if (msmt_valid !== 1'b1 || msmt_channel !== 4'd0 || msmt_value !== 32'd5) begin
            n_fail++; $display("FAIL overrun_head: got valid %0b ch %0d value %0d want 1 0 5", msmt_valid, msmt_channel, msmt_value); end
        ready = 1'b1; tick();
        n_tests++; if (msmt_valid !== 1'b1 || msmt_channel !== 4'd1 || msmt_value !== 32'd50) begin
            n_fail++; $display("FAIL overrun_value: got valid %0b ch %0d value %0d want 1 1 50", msmt_valid, msmt_channel, msmt_value); end
        tick();
        ready = 1'b0;
        run_interval(2, 8);
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        n_tests++; if (overrun !== '0 || msmt_count !== '0) begin
            n_fail++; $display("FAIL clear_state: got overrun %0b count %0h want 0 0", overrun, msmt_count); end
        n_tests++; if (msmt_valid !== 1'b1 || msmt_channel !== 4'd2 || msmt_value !== 32'd8) begin
            n_fail++; $display("FAIL clear_keeps_out: got valid %0b ch %0d value %0d want 1 2 8", msmt_valid, msmt_channel, msmt_value); end
        ready = 1'b1; tick();
        n_tests++; if (msmt_valid !== 1'b0) begin n_fail++; $display("FAIL clear_drain: got valid %0b want 0", msmt_valid); end
    endtask

    task automatic test_restart();
        ready = 1'b1;
        start = 4'b0100; tick(); start = '0;
        repeat (9) tick();
        start = 4'b0100; stop = 4'b0100; tick(); start = '0; stop = '0;
        tick();
        n_tests++; if (msmt_valid !== 1'b1 || msmt_channel !== 4'd2 || msmt_value !== 32'd10) begin
            n_fail++; $display("FAIL restart_first: got valid %0b ch %0d value %0d want 1 2 10", msmt_valid, msmt_channel, msmt_value); end
        repeat (5) tick();
        stop = 4'b0100; tick(); stop = '0;
        tick();
        n_tests++; if (msmt_valid !== 1'b1 || msmt_channel !== 4'd2 || msmt_value !== 32'd7) begin
            n_fail++; $display("FAIL restart_second: got valid %0b ch %0d value %0d want 1 2 7", msmt_valid, msmt_channel, msmt_value); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        start = 4'b1000; tick(); start = '0;
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        stop = 4'b1000; tick(); stop = '0;
        repeat (4) begin
            if (msmt_valid === 1'b1) seen++;
            tick();
        end
        n_tests++; if (seen != 0 || msmt_count[127:96] !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid: got %0d valid cycles count %0d want 0 0", seen, msmt_count[127:96]); end
    endtask

    initial begin
        rst = 1'b1; start = '0; stop = '0; start8 = '0; stop8 = '0;
        avg_en = 1'b0; avg_we = 1'b0; avg_lim = '0; clear = 1'b0; ready = 1'b0; ready8 = 1'b0;
        #1;
        repeat (3) tick();
        rst = 1'b0;
        test_reset();
        test_timing();
        test_saturation();
        test_averaging();
        test_avg_abort();
        test_arbitration();
        test_back_to_back();
        test_overrun_clear();
        test_restart();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
